fetch_stage: RTL



---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/if_id_reg.sv | 63 ++++++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: reset PC, bubble instruction, instruction
// memory address width and the IF/ID payload, plus PC alignment helpers.
package cpu_pkg;

    // Instruction memory is byte addressed with a 16-bit address.
    localparam int IM_ADDR_W = 16;
    localparam int INST_W    = 32;

    // Values shared with decode and the hazard unit.
    localparam logic [IM_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;
    localparam logic [INST_W-1:0]    CPU_NOP_INST = 32'h00000013;

    // Sequential fetch advances by one 32-bit word.
    localparam logic [IM_ADDR_W-1:0] PC_STEP = 16'd4;

    typedef logic [IM_ADDR_W-1:0] pc_t;
    typedef logic [INST_W-1:0]    inst_t;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        inst_t inst;
        pc_t   pc;
        logic  valid;
    } if_id_t;

    // What the IF/ID register does on the coming edge.
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } if_id_op_e;

    // Force a byte address onto a word boundary.
    function automatic pc_t alignPc(input pc_t addr);
        return {addr[IM_ADDR_W-1:2], 2'b00};
    endfunction

    // True when a byte address is not word aligned.
    function automatic logic isMisaligned(input pc_t addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC and a valid bit.
// A bubble request beats stall, and stall beats a fresh load.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_bubble,
    input  logic        i_stall,
    input  logic [31:0] i_inst,
    input  logic [15:0] i_pc,
    output logic [31:0] o_inst,
    output logic [15:0] o_pc,
    output logic        o_valid,
    output logic        o_capture
);

    if_id_op_e w_op;
    if_id_t    r_ifId;

    // Pick this edge's operation from the bubble/stall priority.
    always_comb begin
        w_op = IFID_LOAD;
        if (i_bubble) begin
            w_op = IFID_BUBBLE;
        end else if (i_stall) begin
            w_op = IFID_HOLD;
        end
    end

    // Register update; the PC is still recorded on a bubble so it is never stale X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifId.inst  <= NOP_INST;
            r_ifId.pc    <= 16'h0000;
            r_ifId.valid <= 1'b0;
        end else begin
            case (w_op)
                IFID_BUBBLE: begin
                    r_ifId.inst  <= NOP_INST;
                    r_ifId.pc    <= i_pc;
                    r_ifId.valid <= 1'b0;
                end
                IFID_HOLD: begin
                    r_ifId <= r_ifId;
                end
                default: begin
                    r_ifId.inst  <= i_inst;
                    r_ifId.pc    <= i_pc;
                    r_ifId.valid <= 1'b1;
                end
            endcase
        end
    end

    assign o_inst    = r_ifId.inst;
    assign o_pc      = r_ifId.pc;
    assign o_valid   = r_ifId.valid;
    assign o_capture = (w_op == IFID_LOAD);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register and next-PC selection, drives the
// instruction memory, feeds IF/ID, tracks misaligned redirects and counts
// fresh instruction captures.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = CPU_RESET_PC,
    parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] im_addr,
    output logic [3:0]  im_w_en,
    input  logic [31:0] im_rdata,
    output logic [31:0] id_inst,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_cnt
);

    logic [15:0] r_pc;
    logic [15:0] w_nextPc;
    logic [15:0] w_redirTarget;
    logic        w_bubble;
    logic        w_capture;
    logic        r_misalign;
    logic [31:0] r_fetchCnt;

    assign w_redirTarget = alignPc(redirect_pc);
    assign w_bubble      = redirect_valid | flush;

    // Next PC: a redirect wins even over stall, stall holds, else step one word.
    always_comb begin
        w_nextPc = r_pc + PC_STEP;
        if (redirect_valid) begin
            w_nextPc = w_redirTarget;
        end else if (stall) begin
            w_nextPc = r_pc;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    // Sticky flag for any redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && isMisaligned(redirect_pc)) begin
            r_misalign <= 1'b1;
        end
    end

    // Count only fresh valid captures into IF/ID; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchCnt <= 32'd0;
        end else if (w_capture) begin
            r_fetchCnt <= r_fetchCnt + 32'd1;
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifId (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bubble  (w_bubble),
        .i_stall   (stall),
        .i_inst    (im_rdata),
        .i_pc      (r_pc),
        .o_inst    (id_inst),
        .o_pc      (id_pc),
        .o_valid   (id_valid),
        .o_capture (w_capture)
    );

    // Memory is read-only from fetch, so its write enables stay low.
    assign im_w_en      = 4'b0000;
    assign im_addr      = r_pc;
    assign misalign_err = r_misalign;
    assign fetch_cnt    = r_fetchCnt;

endmodule
